// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multicycle control unit and the MIPS datapath.
// The master side is the control unit: it reads the instruction fields and ALU flag, and drives every strobe.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_zero;
    logic [3:0] alu_func;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, is_zero,
        output alu_func, alu_src_a, alu_src_b, pc_src, pc_write, iord, mem_read,
               mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op, state
    );

    modport slave (
        output opcode, funct, is_zero,
        input  alu_func, alu_src_a, alu_src_b, pc_src, pc_write, iord, mem_read,
               mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives all datapath strobes, ALU function and mux selects.
module mips_multicycle_control (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_control_if.master     bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BEQ     = 4'd8,
        ADDI_EX = 4'd9,
        ADDI_WB = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] rtype_func;
    logic       funct_ok;
    logic       opcode_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        rtype_func = ALU_ADD;
        funct_ok   = 1'b1;
        case (bus.funct)
            6'h20:   rtype_func = ALU_ADD;
            6'h22:   rtype_func = ALU_SUB;
            6'h24:   rtype_func = ALU_AND;
            6'h25:   rtype_func = ALU_OR;
            default: funct_ok   = 1'b0;
        endcase

        case (bus.opcode)
            OP_RTYPE:                             opcode_ok = funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J:  opcode_ok = 1'b1;
            default:                              opcode_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? EXEC : FETCH;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXEC:    state_d = RWB;
            ADDI_EX: state_d = ADDI_WB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        bus.alu_func   = ALU_ADD;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_src     = 2'b00;
        bus.pc_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.pc_write  = 1'b1;
            end
            DECODE: begin
                bus.alu_src_b  = 2'b11;
                bus.illegal_op = ~opcode_ok;
            end
            MEMADR, ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEMRD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_func  = rtype_func;
            end
            RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            ADDI_WB: bus.reg_write = 1'b1;
            BEQ: begin
                bus.alu_src_a = 1'b1;
                bus.alu_func  = ALU_SUB;
                bus.pc_src    = 2'b01;
                bus.pc_write  = bus.is_zero;
            end
            JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
            end
            default: ;
        endcase

        // Reset silences every side-effecting strobe, even before the state register settles.
        if (reset) begin
            bus.pc_write   = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: each driven cycle pushes its expected state
// and full control word; a negedge monitor pops and compares.
module tb_mips_multicycle_control;
    logic clk;
    logic reset;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       illegal_op;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [3:0] alu_func;
    } ctrl_t;

    typedef struct {
        string      name;
        logic [3:0] st;
        ctrl_t      c;
    } exp_t;

    localparam ctrl_t C_RST     = '{alu_src_b: 2'b01, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_FETCH   = '{pc_write: 1'b1, mem_read: 1'b1, ir_write: 1'b1,
                                    alu_src_b: 2'b01, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_DEC     = '{alu_src_b: 2'b11, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_DEC_ILL = '{illegal_op: 1'b1, alu_src_b: 2'b11, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_ADR     = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_MEMRD   = '{iord: 1'b1, mem_read: 1'b1, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_MEMWB   = '{reg_write: 1'b1, mem_to_reg: 1'b1, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_MEMWR   = '{iord: 1'b1, mem_write: 1'b1, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_EXEC    = '{alu_src_a: 1'b1, default: '0};
    localparam ctrl_t C_RWB     = '{reg_write: 1'b1, reg_dst: 1'b1, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_ADDI_WB = '{reg_write: 1'b1, alu_func: 4'b0010, default: '0};
    localparam ctrl_t C_BEQ_T   = '{pc_write: 1'b1, alu_src_a: 1'b1, pc_src: 2'b01, alu_func: 4'b0110, default: '0};
    localparam ctrl_t C_BEQ_F   = '{alu_src_a: 1'b1, pc_src: 2'b01, alu_func: 4'b0110, default: '0};
    localparam ctrl_t C_JUMP    = '{pc_write: 1'b1, pc_src: 2'b10, alu_func: 4'b0010, default: '0};

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Push the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string name, input logic [3:0] st, input ctrl_t c);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.c    = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t  e;
            ctrl_t a;
            e = sb.pop_front();
            a = '{pc_write: bus.pc_write, mem_read: bus.mem_read, mem_write: bus.mem_write,
                  ir_write: bus.ir_write, reg_write: bus.reg_write, illegal_op: bus.illegal_op,
                  iord: bus.iord, reg_dst: bus.reg_dst, mem_to_reg: bus.mem_to_reg,
                  alu_src_a: bus.alu_src_a, alu_src_b: bus.alu_src_b, pc_src: bus.pc_src,
                  alu_func: bus.alu_func};
            check({e.name, ".state"}, 32'(bus.state), 32'(e.st));
            check({e.name, ".ctrl"}, 32'(a), 32'(e.c));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fn_tab [4];
        logic [3:0] fu_tab [4];
        ctrl_t      ce;
        fn_tab = '{6'h22, 6'h20, 6'h24, 6'h25};
        fu_tab = '{4'b0110, 4'b0010, 4'b0000, 4'b0001};

        reset       = 1'b1;
        bus.opcode  = 6'h00;
        bus.funct   = 6'h22;
        bus.is_zero = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst0", 4'd0, C_RST);
        cyc("rst1", 4'd0, C_RST);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            bus.opcode  = 6'h00;
            bus.funct   = fn_tab[i];
            ce          = C_EXEC;
            ce.alu_func = fu_tab[i];
            cyc($sformatf("r%0d_fetch", i), 4'd0, C_FETCH);
            cyc($sformatf("r%0d_dec", i),   4'd1, C_DEC);
            cyc($sformatf("r%0d_exec", i),  4'd6, ce);
            cyc($sformatf("r%0d_wb", i),    4'd7, C_RWB);
        end

        bus.opcode = 6'h23;
        cyc("lw_fetch", 4'd0, C_FETCH);
        cyc("lw_dec",   4'd1, C_DEC);
        cyc("lw_adr",   4'd2, C_ADR);
        cyc("lw_rd",    4'd3, C_MEMRD);
        cyc("lw_wb",    4'd4, C_MEMWB);

        bus.opcode = 6'h2B;
        cyc("sw_fetch", 4'd0, C_FETCH);
        cyc("sw_dec",   4'd1, C_DEC);
        cyc("sw_adr",   4'd2, C_ADR);
        cyc("sw_wr",    4'd5, C_MEMWR);

        bus.opcode  = 6'h04;
        bus.is_zero = 1'b1;
        cyc("beqt_fetch", 4'd0, C_FETCH);
        cyc("beqt_dec",   4'd1, C_DEC);
        cyc("beqt_br",    4'd8, C_BEQ_T);
        bus.is_zero = 1'b0;
        cyc("beqf_fetch", 4'd0, C_FETCH);
        cyc("beqf_dec",   4'd1, C_DEC);
        cyc("beqf_br",    4'd8, C_BEQ_F);

        bus.opcode = 6'h3F;
        cyc("ill_op_fetch", 4'd0, C_FETCH);
        cyc("ill_op_dec",   4'd1, C_DEC_ILL);
        bus.opcode = 6'h00;
        bus.funct  = 6'h27;
        cyc("ill_fn_fetch", 4'd0, C_FETCH);
        cyc("ill_fn_dec",   4'd1, C_DEC_ILL);

        bus.opcode = 6'h08;
        cyc("addi_fetch", 4'd0, C_FETCH);
        cyc("addi_dec",   4'd1, C_DEC);
        cyc("addi_ex",    4'd9, C_ADR);
        cyc("addi_wb",    4'd10, C_ADDI_WB);

        cyc("addr_fetch", 4'd0, C_FETCH);
        cyc("addr_dec",   4'd1, C_DEC);
        reset = 1'b1;
        cyc("addr_ex_rst", 4'd9, C_ADR);
        reset = 1'b0;

        bus.opcode = 6'h02;
        cyc("j_fetch", 4'd0, C_FETCH);
        cyc("j_dec",   4'd1, C_DEC);
        cyc("j_jump",  4'd11, C_JUMP);
        cyc("post_j",  4'd0, C_FETCH);

        check("drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
